// File: rtl/lsu_pkg.sv
// Shared types and default address map for the load/store unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    F_B  = 3'b000,
    F_H  = 3'b001,
    F_W  = 3'b010,
    F_BU = 3'b100,
    F_HU = 3'b101
  } funct3_e;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_e;

  localparam logic [15:0] DEF_DMEM_BASE = 16'h2000;
  localparam logic [15:0] DEF_OUT_BASE  = 16'h7000;
  localparam logic [15:0] DEF_IN_BASE   = 16'h7800;

  // Halfwords must be 2-byte aligned, words 4-byte aligned.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    return ((funct3 == F_H || funct3 == F_HU) && off[0]) ||
           ((funct3 == F_W) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_mmio_if.sv
// Core-to-LSU request/response bus.
interface lsu_mmio_if;
  logic        i_req;
  logic        i_we;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_stall;
  logic        o_rvalid;
  logic [31:0] o_rdata;
  logic        o_misaligned;

  modport master (
    output i_req, i_we, i_funct3, i_addr, i_wdata,
    input  o_stall, o_rvalid, o_rdata, o_misaligned
  );

  modport slave (
    input  i_req, i_we, i_funct3, i_addr, i_wdata,
    output o_stall, o_rvalid, o_rdata, o_misaligned
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables/lane replication and load extract/extend.
module lsu_align (
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wlanes_o,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;

  // Bring the addressed byte/half down to bit 0.
  assign shifted = rword_i >> {off_i, 3'b000};

  // Size is funct3[1:0]; funct3[2] selects zero-extension.
  always_comb begin
    be_o     = 4'b0000;
    wlanes_o = '0;
    rdata_o  = '0;
    unique case (funct3_i[1:0])
      2'b00: begin
        be_o     = 4'b0001 << off_i;
        wlanes_o = {4{wdata_i[7:0]}};
        rdata_o  = funct3_i[2] ? 32'(shifted[7:0]) : {{24{shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        be_o     = off_i[1] ? 4'b1100 : 4'b0011;
        wlanes_o = {2{wdata_i[15:0]}};
        rdata_o  = funct3_i[2] ? 32'(shifted[15:0]) : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: begin
        be_o     = 4'b1111;
        wlanes_o = wdata_i;
        rdata_o  = rword_i;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mmio.sv
// Load/store unit: decodes requests into DMEM, output registers and switch input.
module lsu_mmio
  import lsu_pkg::*;
#(
  parameter int unsigned DMEM_WORDS  = 2048,
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned NUM_OUT     = 8,
  parameter int unsigned IN_WIDTH    = 32,
  parameter logic [15:0] DMEM_BASE   = DEF_DMEM_BASE,
  parameter logic [15:0] OUT_BASE    = DEF_OUT_BASE,
  parameter logic [15:0] IN_BASE     = DEF_IN_BASE
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  lsu_mmio_if.slave              bus,
  input  logic [IN_WIDTH-1:0]    i_io_in,
  output logic [NUM_OUT*32-1:0]  o_io_out
);

  localparam int unsigned AW      = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;
  localparam int unsigned OW      = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam int unsigned CW      = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int unsigned DMEM_LO = 32'(DMEM_BASE);
  localparam int unsigned DMEM_HI = DMEM_LO + 4 * DMEM_WORDS;
  localparam int unsigned OUT_LO  = 32'(OUT_BASE);
  localparam int unsigned OUT_HI  = OUT_LO + 4 * NUM_OUT;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [31:0]         mem_q [DMEM_WORDS];
  logic [31:0]         out_q [NUM_OUT];
  logic [IN_WIDTH-1:0] sync1_q, sync2_q;

  logic [31:0]   a32, dmem_off, out_off, rword, wlanes, ext_rdata;
  logic [AW-1:0] dmem_idx;
  logic [OW-1:0] out_idx;
  logic [3:0]    be;
  logic          dmem_hit, out_hit, in_hit, mis_c;
  logic          stall_c, rvalid_c, mis_flag_c, dmem_we, out_we;
  logic          stall_o, rvalid_o, mis_o;
  logic          unused_bits;

  // Address decode on the low 16 bits.
  assign a32      = 32'(bus.i_addr[15:0]);
  assign dmem_hit = (a32 >= DMEM_LO) && (a32 < DMEM_HI);
  assign out_hit  = (a32 >= OUT_LO) && (a32 < OUT_HI);
  assign in_hit   = (bus.i_addr[15:2] == IN_BASE[15:2]);
  assign mis_c    = is_misaligned(bus.i_funct3, bus.i_addr[1:0]);
  assign dmem_off = a32 - DMEM_LO;
  assign out_off  = a32 - OUT_LO;
  assign dmem_idx = dmem_off[AW+1:2];
  assign out_idx  = out_off[OW+1:2];

  assign unused_bits = ^{bus.i_addr[31:16], dmem_off[31:AW+2], dmem_off[1:0],
                         out_off[31:OW+2], out_off[1:0], IN_BASE[1:0]};

  // Source word for loads; the core holds the address through WAIT.
  always_comb begin
    rword = '0;
    if (dmem_hit)     rword = mem_q[dmem_idx];
    else if (out_hit) rword = out_q[out_idx];
    else if (in_hit)  rword = 32'(sync2_q);
  end

  lsu_align u_align (
    .funct3_i (bus.i_funct3),
    .off_i    (bus.i_addr[1:0]),
    .wdata_i  (bus.i_wdata),
    .rword_i  (rword),
    .be_o     (be),
    .wlanes_o (wlanes),
    .rdata_o  (ext_rdata)
  );

  // Request sequencing: MMIO completes immediately, DMEM waits MEM_LATENCY cycles.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall_c    = 1'b0;
    rvalid_c   = 1'b0;
    mis_flag_c = 1'b0;
    dmem_we    = 1'b0;
    out_we     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.i_req) begin
          if (mis_c) begin
            rvalid_c   = 1'b1;
            mis_flag_c = 1'b1;
          end else if (dmem_hit) begin
            stall_c = 1'b1;
            state_d = S_WAIT;
            cnt_d   = CW'(MEM_LATENCY - 1);
          end else begin
            rvalid_c = 1'b1;
            out_we   = bus.i_we & out_hit;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          stall_c = 1'b1;
          cnt_d   = cnt_q - CW'(1);
        end else begin
          rvalid_c = 1'b1;
          dmem_we  = bus.i_we;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state and latency counter; reset aborts any pending access.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake outputs are held quiet while reset is asserted.
  assign stall_o          = i_rst_n & stall_c;
  assign rvalid_o         = i_rst_n & rvalid_c;
  assign mis_o            = i_rst_n & mis_flag_c;
  assign bus.o_stall      = stall_o;
  assign bus.o_rvalid     = rvalid_o;
  assign bus.o_misaligned = mis_o;
  assign bus.o_rdata      = (rvalid_o && !bus.i_we && !mis_o) ? ext_rdata : '0;

  // Data memory: byte-enabled synchronous write, contents not reset.
  always_ff @(posedge i_clk) begin
    if (dmem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[dmem_idx][8*b +: 8] <= wlanes[8*b +: 8];
      end
    end
  end

  // Output registers with byte-merged stores.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < int'(NUM_OUT); k++) out_q[k] <= '0;
    end else if (out_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) out_q[out_idx][8*b +: 8] <= wlanes[8*b +: 8];
      end
    end
  end

  // Two-flop synchroniser for the switch input.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= i_io_in;
      sync2_q <= sync1_q;
    end
  end

  for (genvar k = 0; k < int'(NUM_OUT); k++) begin : g_out
    assign o_io_out[32*k +: 32] = out_q[k];
  end

endmodule

// File: doc/lsu_mmio.md
# lsu_mmio

Parametrised load/store unit for the single-cycle RISC-V core, successor to the current fixed-map LSU. It decodes each core memory request into data memory, output-peripheral registers or the synchronised switch input. It performs byte/half/word store merging and sign/zero-extended loads, and it traps misaligned accesses. It stalls the core with a handshake while a multi-cycle data-memory access is in flight.

## Interface
Parameters:
- DMEM_WORDS, 2048, data-memory depth in 32-bit words (power of 2)
- MEM_LATENCY, 2, cycles the core is stalled per data-memory access (≥1)
- NUM_OUT, 8, number of 32-bit output registers (1..16)
- IN_WIDTH, 32, switch input width (≤32)
- DMEM_BASE, 16'h2000, data-memory base (addr[15:0])
- OUT_BASE, 16'h7000, output-register base
- IN_BASE, 16'h7800, input-register address

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_req  in  1  request valid; core holds i_addr/i_wdata/i_we/i_funct3 stable while o_stall=1
- i_we  in  1  1=store, 0=load
- i_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU only for loads)
- i_addr  in  32  byte address; only [15:0] decoded
- i_wdata  in  32  store data, right-aligned
- o_stall  out  1  hold the core
- o_rvalid  out  1  access completes this cycle
- o_rdata  out  32  extended load data, valid with o_rvalid && !i_we
- o_misaligned  out  1  one-cycle misaligned-access flag
- i_io_in  in  IN_WIDTH  asynchronous switch input
- o_io_out  out  NUM_OUT*32  output registers; word k at [32k+31:32k]

## Operation
- Decode: DMEM hit if DMEM_BASE ≤ a < DMEM_BASE+4*DMEM_WORDS. OUT hit if OUT_BASE ≤ a < OUT_BASE+4*NUM_OUT. IN hit if a[15:2]==IN_BASE[15:2]. Anything else is unmapped.
- Misaligned: H/HU with a[0]=1, or W with a[1:0]≠0. Response is o_misaligned=1, o_rvalid=1, o_rdata=0, no write, no stall. This check takes priority over decode.
- Store merge: B writes lane a[1:0], H writes lanes {a[1],0}+{0,1}, W writes all lanes. Unwritten bytes are preserved.
- Load: the selected byte/half is shifted to bit 0. B/H sign-extend from bit 7/15; BU/HU zero-extend.
- IN reads return the 2-flop-synchronised i_io_in, zero-extended. Stores to IN are dropped.
- Unmapped: loads return 0, stores are dropped, and the access completes in one cycle.
- FSM states:
  - IDLE: on i_req with a valid DMEM hit, o_stall=1 and go to WAIT with cnt=MEM_LATENCY-1. For any other request, complete in the same cycle: o_rvalid=1, and OUT stores commit at the clock edge.
  - WAIT: o_stall=(cnt≠0). When cnt==0: o_rvalid=1, o_rdata is valid, a DMEM store commits at this edge, then return to IDLE. Otherwise decrement cnt.
- When i_req=0 in IDLE: o_stall=0, o_rvalid=0.
- Reset values: state IDLE, cnt 0, all output registers 0, sync flops 0, o_stall 0, o_rvalid 0, o_misaligned 0, o_rdata 0. DMEM contents are not reset.

## Timing
- MMIO, unmapped and misaligned accesses take 1 cycle with 0 stall cycles. Load data is combinational in the request cycle.
- DMEM access: o_stall is high for exactly MEM_LATENCY cycles starting in the request cycle. Completion (o_rvalid) occurs MEM_LATENCY cycles after the request cycle.
- Back-to-back DMEM requests: a new request may be accepted in the cycle after completion. There is no bubble beyond that.
- o_io_out updates on the clock edge that ends the store cycle.
- i_io_in to readable value: 2 cycles.
- Reset asserted mid-WAIT aborts the access. The pending store is not committed, and o_stall drops immediately.
- o_rdata is 0 whenever o_rvalid=0 or i_we=1.

## Structure
- Package lsu_pkg:
  - funct3 enum (F_B, F_H, F_W, F_BU, F_HU)
  - FSM state enum (S_IDLE, S_WAIT)
  - default address-map constants
- Sub-module lsu_align (combinational): store byte-enable and merge generation, plus load extract/extend. It is shared by the DMEM and OUT paths.
- The DMEM array is internal, with a synchronous write gated by byte enables.

## Test plan
- Reset then SW 0x12345678 to 0x2000 and LW 0x2000: 2 stall cycles each; load returns 0x12345678 on the o_rvalid cycle.
- SB 0xAB to 0x2002 over 0x12345678, then LB 0x2002 returns 0xFFFFFFAB and LBU returns 0x000000AB; LW returns 0x12AB5678.
- SH 0x8001 to 0x7006 with NUM_OUT=8, then LH 0x7006 returns 0xFFFF8001 with no stall; o_io_out[63:48]=0x8001, other bytes unchanged.
- LW 0x2001: o_misaligned=1, o_rdata=0, no stall, memory unchanged. SH to 0x7003 raises the same flag with no write.
- Drive i_io_in=0x5A then LW 0x7800: returns 0x5A from the 3rd cycle after the change. A store to 0x7800 has no effect; LW 0x5000 returns 0.
- SW to 0x2004 with i_rst_n pulsed low during WAIT: o_stall drops immediately and o_io_out=0. A subsequent LW 0x2004 does not return the aborted data.
